// File: rtl/ras_ckpt.sv
// Return address stack with a speculative copy updated at fetch and a committed copy
// updated at retire; a flush restores the speculative copy from the committed one.
module ras_ckpt #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spec_push,
  input  logic                  spec_pop,
  input  logic [ADDR_WIDTH-1:0] spec_push_addr,
  input  logic                  commit_push,
  input  logic                  commit_pop,
  input  logic [ADDR_WIDTH-1:0] commit_push_addr,
  input  logic                  flush,
  output logic                  top_valid,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic [CNT_W-1:0]      spec_count,
  output logic [CNT_W-1:0]      commit_count,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [ADDR_WIDTH-1:0] spec_ent_q [DEPTH];
  logic [ADDR_WIDTH-1:0] spec_ent_d [DEPTH];
  logic [ADDR_WIDTH-1:0] commit_ent_q [DEPTH];
  logic [ADDR_WIDTH-1:0] commit_ent_d [DEPTH];
  logic [PTR_W-1:0]      spec_top_q, spec_top_d, commit_top_q, commit_top_d;
  logic [CNT_W-1:0]      spec_cnt_q, spec_cnt_d, commit_cnt_q, commit_cnt_d;
  logic                  underflow_q, underflow_d;

  // Committed stack next state; also the restore source on flush.
  always_comb begin
    commit_ent_d = commit_ent_q;
    commit_top_d = commit_top_q;
    commit_cnt_d = commit_cnt_q;
    if (commit_push && (!commit_pop || commit_cnt_q == '0)) begin
      commit_top_d               = commit_top_q + PtrOne;
      commit_ent_d[commit_top_d] = commit_push_addr;
      if (commit_cnt_q != CntMax) commit_cnt_d = commit_cnt_q + CntOne;
    end else if (commit_push && commit_pop) begin
      commit_ent_d[commit_top_q] = commit_push_addr;
    end else if (commit_pop && commit_cnt_q != '0) begin
      commit_top_d = commit_top_q - PtrOne;
      commit_cnt_d = commit_cnt_q - CntOne;
    end
  end

  always_comb begin
    spec_ent_d  = spec_ent_q;
    spec_top_d  = spec_top_q;
    spec_cnt_d  = spec_cnt_q;
    underflow_d = 1'b0;
    if (flush) begin
      spec_ent_d = commit_ent_d;
      spec_top_d = commit_top_d;
      spec_cnt_d = commit_cnt_d;
    end else if (spec_push && (!spec_pop || spec_cnt_q == '0)) begin
      spec_top_d             = spec_top_q + PtrOne;
      spec_ent_d[spec_top_d] = spec_push_addr;
      if (spec_cnt_q != CntMax) spec_cnt_d = spec_cnt_q + CntOne;
    end else if (spec_push && spec_pop) begin
      spec_ent_d[spec_top_q] = spec_push_addr;
    end else if (spec_pop) begin
      if (spec_cnt_q != '0) begin
        spec_top_d = spec_top_q - PtrOne;
        spec_cnt_d = spec_cnt_q - CntOne;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        spec_ent_q[i]   <= '0;
        commit_ent_q[i] <= '0;
      end
      spec_top_q   <= '0;
      commit_top_q <= '0;
      spec_cnt_q   <= '0;
      commit_cnt_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      spec_ent_q   <= spec_ent_d;
      commit_ent_q <= commit_ent_d;
      spec_top_q   <= spec_top_d;
      commit_top_q <= commit_top_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  assign top_addr     = spec_ent_q[spec_top_q];
  assign top_valid    = (spec_cnt_q != '0);
  assign spec_count   = spec_cnt_q;
  assign commit_count = commit_cnt_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios plus a random run, with DEPTH=16 and DEPTH=4
// instances driven in lockstep against queue-based stack models.
module tb_ras_ckpt;

  typedef logic [31:0] q_t[$];

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sp = 1'b0, spo = 1'b0, cp = 1'b0, cpo = 1'b0, fl = 1'b0;
  logic [31:0] sa = '0, ca = '0;

  logic        tv0, uf0, tv1, uf1;
  logic [31:0] ta0, ta1;
  logic [4:0]  sc0, cc0;
  logic [2:0]  sc1, cc1;

  int ncmp = 0;
  int nfail = 0;

  q_t ms[2];
  q_t mc[2];
  bit mu[2];

  ras_ckpt #(.DEPTH(16), .ADDR_WIDTH(32)) u_d16 (
    .clk(clk), .resetn(resetn), .spec_push(sp), .spec_pop(spo), .spec_push_addr(sa),
    .commit_push(cp), .commit_pop(cpo), .commit_push_addr(ca), .flush(fl),
    .top_valid(tv0), .top_addr(ta0), .spec_count(sc0), .commit_count(cc0), .underflow(uf0)
  );

  ras_ckpt #(.DEPTH(4), .ADDR_WIDTH(32)) u_d4 (
    .clk(clk), .resetn(resetn), .spec_push(sp), .spec_pop(spo), .spec_push_addr(sa),
    .commit_push(cp), .commit_pop(cpo), .commit_push_addr(ca), .flush(fl),
    .top_valid(tv1), .top_addr(ta1), .spec_count(sc1), .commit_count(cc1), .underflow(uf1)
  );

  always #5 clk = ~clk;

  // Stack as a queue, newest at the back; overflow drops the oldest.
  function automatic q_t apply(q_t q, bit push, bit pop, logic [31:0] a, int d);
    if (push && (!pop || q.size() == 0)) begin
      q.push_back(a);
      if (q.size() > d) void'(q.pop_front());
    end else if (push && pop) begin
      q[q.size()-1] = a;
    end else if (pop && q.size() > 0) begin
      void'(q.pop_back());
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int k = 0; k < 2; k++) begin
      ms[k].delete();
      mc[k].delete();
      mu[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = (k == 0) ? 16 : 4;
      mc[k] = apply(mc[k], cp, cpo, ca, d);
      if (fl) begin
        ms[k] = mc[k];
        mu[k] = 1'b0;
      end else begin
        mu[k] = spo && !sp && ms[k].size() == 0;
        ms[k] = apply(ms[k], sp, spo, sa, d);
      end
    end
  endtask

  task automatic check_all();
    chk("d16.spec_count", 32'(sc0), 32'(ms[0].size()));
    chk("d16.commit_count", 32'(cc0), 32'(mc[0].size()));
    chk("d16.top_valid", 32'(tv0), 32'(ms[0].size() != 0));
    chk("d16.underflow", 32'(uf0), 32'(mu[0]));
    if (ms[0].size() != 0) chk("d16.top_addr", ta0, ms[0][ms[0].size()-1]);
    chk("d4.spec_count", 32'(sc1), 32'(ms[1].size()));
    chk("d4.commit_count", 32'(cc1), 32'(mc[1].size()));
    chk("d4.top_valid", 32'(tv1), 32'(ms[1].size() != 0));
    chk("d4.underflow", 32'(uf1), 32'(mu[1]));
    if (ms[1].size() != 0) chk("d4.top_addr", ta1, ms[1][ms[1].size()-1]);
  endtask

  task automatic drive(input bit isp, input bit ispo, input logic [31:0] isa, input bit icp,
                       input bit icpo, input logic [31:0] ica, input bit ifl);
    sp = isp; spo = ispo; sa = isa; cp = icp; cpo = icpo; ca = ica; fl = ifl;
    @(posedge clk);
    if (!resetn) clear_models();
    else model_step();
    #1;
    sp = 0; spo = 0; cp = 0; cpo = 0; fl = 0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_models();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    clear_models();
    #2;
    chk("reset.spec_count", 32'(sc0), 0);
    chk("reset.commit_count", 32'(cc0), 0);
    chk("reset.top_valid", 32'(tv0), 0);
    chk("reset.top_addr", ta0, 0);
    chk("reset.underflow", 32'(uf0), 0);
    do_reset();

    // Basic push/pop
    drive(1, 0, 32'h100, 0, 0, 0, 0);
    drive(1, 0, 32'h200, 0, 0, 0, 0);
    drive(1, 0, 32'h300, 0, 0, 0, 0);
    chk("push3.top_addr", ta0, 32'h300);
    chk("push3.count", 32'(sc0), 3);
    chk("push3.valid", 32'(tv0), 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("pop.top_addr", ta0, 32'h200);
    chk("pop.count", 32'(sc0), 2);

    // Overflow wrap, drain, underflow
    do_reset();
    for (int i = 0; i < 18; i++) drive(1, 0, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
    chk("ovf.count", 32'(sc0), 16);
    chk("ovf.top_addr", ta0, 32'h1044);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0, 0, 0, 0);
    chk("drain.last_top", ta0, 32'h1008);
    chk("drain.last_valid", 32'(tv0), 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("drain.empty", 32'(tv0), 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("udf.pulse", 32'(uf0), 1);
    chk("udf.count", 32'(sc0), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("udf.one_cycle", 32'(uf0), 0);

    // Tail-call replace, and push+pop on empty
    do_reset();
    drive(1, 0, 32'h40, 0, 0, 0, 0);
    drive(1, 1, 32'h80, 0, 0, 0, 0);
    chk("repl.top_addr", ta0, 32'h80);
    chk("repl.count", 32'(sc0), 1);
    do_reset();
    drive(1, 1, 32'h90, 0, 0, 0, 0);
    chk("pp_empty.count", 32'(sc0), 1);
    chk("pp_empty.top_addr", ta0, 32'h90);
    chk("pp_empty.underflow", 32'(uf0), 0);

    // Flush restores from commit_next
    do_reset();
    drive(1, 0, 32'hA0, 1, 0, 32'hA0, 0);
    drive(1, 0, 32'hB0, 1, 0, 32'hB0, 0);
    drive(1, 0, 32'hC0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 32'hEE, 1, 0, 32'hD0, 1);
    chk("flush.spec_count", 32'(sc0), 3);
    chk("flush.top_addr", ta0, 32'hD0);
    chk("flush.commit_count", 32'(cc0), 3);
    chk("flush.underflow", 32'(uf0), 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("flush.pop_top", ta0, 32'hB0);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 32'h500 + 32'(i), 1, 0, 32'h600 + 32'(i), 0);
    chk("arst.pre_count", 32'(sc0), 5);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    clear_models();
    #1;
    chk("arst.spec_count", 32'(sc0), 0);
    chk("arst.commit_count", 32'(cc0), 0);
    chk("arst.top_valid", 32'(tv0), 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("arst.underflow", 32'(uf0), 1);

    // Random run against both models
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      bit rsp, rspo, rcp, rcpo, rfl;
      rsp  = ($urandom_range(0, 9) < 5);
      rspo = ($urandom_range(0, 9) < 4);
      rcp  = ($urandom_range(0, 9) < 4);
      rcpo = ($urandom_range(0, 9) < 3);
      rfl  = ($urandom_range(0, 19) == 0);
      drive(rsp, rspo, $urandom, rcp, rcpo, $urandom, rfl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised return address stack (RAS) for the branch predictor.
- A speculative stack is updated at fetch: push on call, pop on return. Its top supplies the predicted return target.
- A committed stack is updated at retire.
- On pipeline flush the speculative stack (contents, pointer, count) is restored from the committed stack in one cycle.
- Both stacks are circular: overflow overwrites the oldest entry rather than saturating.

Parameters:
- DEPTH, 16, entries per stack; power of two, >= 2.
- ADDR_WIDTH, 32, return address width.
- PTR_W, $clog2(DEPTH), pointer width (localparam).
- CNT_W, $clog2(DEPTH+1), occupancy count width (localparam).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- spec_push  in  1  call predicted at fetch.
- spec_pop  in  1  return predicted at fetch.
- spec_push_addr  in  ADDR_WIDTH  return address for spec_push (call pc + 8).
- commit_push  in  1  call retired.
- commit_pop  in  1  return retired.
- commit_push_addr  in  ADDR_WIDTH  return address for commit_push.
- flush  in  1  pipeline redirect; restore speculative state.
- top_valid  out  1  speculative stack non-empty.
- top_addr  out  ADDR_WIDTH  speculative top entry.
- spec_count  out  CNT_W  speculative occupancy.
- commit_count  out  CNT_W  committed occupancy.
- underflow  out  1  one-cycle pulse: spec pop on empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: all storage entries, pointers and counts = 0. Outputs: top_valid=0, top_addr=0, spec_count=0, commit_count=0, underflow=0.
- Each stack holds: entry array [DEPTH] of ADDR_WIDTH (flops, not RAM), top pointer (PTR_W), count (CNT_W). The top pointer addresses the most recent entry.
- Read path is combinational, zero latency:
  - top_addr = spec_entry[spec_top].
  - top_valid = (spec_count != 0).
  - top_addr is returned even when invalid; consumers must gate on top_valid.
- Per-stack update, identical rules for spec_* and commit_*; all effects take place at the next rising clk edge:
  - push only: top <= top+1 mod DEPTH; entry[top+1] <= push_addr; count <= min(count+1, DEPTH). At count==DEPTH this overwrites the oldest entry (wrap); count stays DEPTH.
  - pop only, count>0: top <= top-1 mod DEPTH; count <= count-1. Entry contents unchanged.
  - pop only, count==0: no state change. For the speculative stack only, underflow pulses high for the next cycle.
  - push and pop, count>0 (tail-call replace): entry[top] <= push_addr; top and count unchanged.
  - push and pop, count==0: treated as push only; no underflow.
  - neither: hold.
- Flush:
  - Commit update for the cycle is computed first, giving commit_next (entries, pointer, count).
  - Speculative state <= commit_next: full array copy, top and count.
  - spec_push and spec_pop in the flush cycle are ignored. underflow is not raised.
- underflow is registered: asserted in the cycle after the offending pop, low otherwise.
- Pointer arithmetic is modulo DEPTH by natural PTR_W wrap. Count arithmetic never exceeds DEPTH and never goes below 0.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first operation after resetn deassertion behaves as on an empty stack.
- Inputs are not checked for consistency. The commit stack follows retirement exactly; no protection is applied against commit_pop on an empty commit stack beyond the count floor.

Test Plan:
- Reset, then spec_push 0x100, 0x200, 0x300 on consecutive cycles -> top_addr=0x300, spec_count=3, top_valid=1. Then spec_pop -> next cycle top_addr=0x200, spec_count=2.
- DEPTH=16: 18 spec_pushes of 0x1000+4*i (i=0..17) -> spec_count=16, top_addr=0x1044. 16 pops -> last valid top read before final pop is 0x1008; then top_valid=0. A further pop -> underflow=1 for exactly one cycle, spec_count stays 0.
- After push 0x40, apply spec_push 0x80 and spec_pop together -> top_addr=0x80, spec_count=1. On an empty stack, push+pop with addr 0x90 -> spec_count=1, top_addr=0x90, underflow=0.
- Commit pushes 0xA0, 0xB0. Speculative pushes 0xA0, 0xB0, 0xC0, then pop, pop, pop, pop. Assert flush together with commit_push 0xD0 and spec_push 0xEE -> next cycle spec_count=3, top_addr=0xD0, commit_count=3; then spec_pop -> top_addr=0xB0.
- Assert resetn=0 between clock edges while spec_count=5 -> spec_count, commit_count, top_valid read 0 immediately, before the next edge. Release, then spec_pop -> underflow pulses.
- Random push/pop/flush sequence (>=10k cycles, DEPTH=4 and DEPTH=16) against a reference model -> top_addr, top_valid, spec_count, commit_count and underflow match every cycle.
